s2p_converter: RTL and testbench
================================

# s2p_converter

Serial-to-parallel converter that sits directly downstream of the parallel-to-serial stage. It accepts one bit per cycle on a valid/ready serial interface, MSB first, and assembles N-bit words. Each completed word is presented on a valid/ready parallel interface to the consuming logic. Used together, the two stages form a lossless parallel→serial→parallel link: a word entered upstream emerges unchanged here.

## Interface
- `N`, default 4: word width in bits; legal N ≥ 2.
- `CNT_W`, default `$clog2(N)`: localparam, bit-counter width; not overridable.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `clr`  in  1  synchronous abort; discards any partial word.
- `ser_valid`  in  1  upstream has a bit on `ser_data`.
- `ser_data`  in  1  serial bit, MSB of each word first.
- `ser_ready`  out  1  block accepts a bit this cycle.
- `par_data`  out  N  assembled word.
- `par_valid`  out  1  `par_data` holds a complete word.
- `par_ready`  in  1  downstream takes the word this cycle.

## Operation
- A serial beat is `ser_valid && ser_ready` in a cycle. A parallel beat is `par_valid && par_ready` in a cycle.
- On each serial beat: `shift_reg <= {shift_reg[N-2:0], ser_data}` and `count <= count + 1`.
- The first bit received becomes `par_data[N-1]`.
- The Nth bit is the beat with `count == N-1`. On that beat, `count` wraps to 0 and the word is complete.
- Base FSM (states in `s2p_pkg`):
  - FILL: `ser_ready = 1`. On the Nth bit, go to HOLD.
  - HOLD: `ser_ready = 0`, `par_valid = 1`, `par_data = shift_reg`. On `par_ready`, go to FILL.
  - `ser_valid` is ignored in HOLD.
- `ser_data` is ignored when `ser_valid = 0`. No bit is consumed without a beat.
- `clr` behaviour:
  - `clr = 1` gives `count <= 0` and state FILL, and drops `par_valid`. This holds even mid-word or while in HOLD.
  - `clr` has priority over a simultaneous serial or parallel beat; that beat is discarded.
- Reset mid-operation behaves like `clr`, but takes effect immediately (asynchronously).
- Reset values: state FILL, `count = 0`, `shift_reg = 0`, `par_data = 0`, `par_valid = 0`, `ser_ready = 1`.

## Timing
- Without the macro:
  - `par_valid` rises the cycle after the Nth serial beat.
  - At least one HOLD cycle per word, so the best case is N+1 cycles per word.
  - `ser_ready` is registered-state only; there is no combinational path from `par_ready`.
- With the macro:
  - `par_valid` also rises the cycle after the Nth beat.
  - Sustained rate is N cycles per word when `par_ready` is held high.
- `par_data` is stable while `par_valid = 1 && par_ready = 0`. It changes only after a parallel beat or `clr`.
- Upstream `ser_valid`/`ser_data` must stay stable until `ser_ready`; no assumption is made about a gap between words.

## Configuration
- Macro: `S2P_DOUBLE_BUF_EN`.
- Undefined: the base two-state FSM described above.
- Defined: a separate output register `out_reg` plus `out_valid`; the HOLD state is not compiled and the block always shifts.
  - `ser_ready = !(count == N-1 && out_valid && !par_ready)`. This is a combinational path from `par_ready`.
  - On the Nth bit: `out_reg <= {shift_reg[N-2:0], ser_data}` and `out_valid <= 1`.
  - A parallel beat with no simultaneous Nth bit clears `out_valid`.
  - A simultaneous parallel beat and Nth bit loads the new word with `out_valid` kept at 1. No word is lost or duplicated.
  - `par_data = out_reg` and `par_valid = out_valid`.
  - `clr` and `rst` clear `out_valid`, and `rst` also clears `out_reg`.

## Structure
- `s2p_pkg` holds the state enum typedef (FILL = 0, HOLD = 1, 1-bit logic) and any shared width constants. The upstream stage imports the same package for its RX/TX enum.
- Sub-module `s2p_out_reg` is the holding register with its valid/ready logic. It is instantiated only under `S2P_DOUBLE_BUF_EN`.
- Top-level target size: 120–250 lines of RTL.

## Test plan
- Basic transfer, N = 4: serial bits 1,0,1,1 sent back-to-back with `par_ready = 1`. Required: `par_data = 4'b1011`, `par_valid` high one cycle after the 4th beat.
- Back-pressure: `par_ready = 0` for 5 cycles after word 4'hA. Required: `par_data` holds 4'hA and `ser_ready = 0` (base); with the macro, 3 bits of the next word are accepted, then `ser_ready` drops.
- Throughput: 8 words streamed continuously with `par_ready = 1`. Required: one word per 5 cycles (base) and one per 4 cycles (macro); no loss, order preserved.
- Abort: `clr` pulsed after 2 bits. Required: `count = 0`; the next 4 bits 0,1,1,0 produce exactly `4'b0110`.
- Reset mid-HOLD: `rst` asserted asynchronously while `par_valid = 1`. Required: `par_valid = 0` and `par_data = 0` immediately, and `ser_ready = 1` after release.
- Loopback with the parallel-to-serial stage: 100 random N = 8 words with random stalls on both interfaces. Required: the output sequence equals the input sequence.

Source files
------------

// File: rtl/s2p_pkg.sv
// ============================================================================
// s2p_pkg: shared state encoding and width helper for the s2p/p2s link
// Rev 1.0
// ============================================================================
`default_nettype none

package s2p_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } s2p_state_e;

   // Guarantees a counter at least one bit wide even for degenerate widths.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/s2p_converter_if.sv
// ============================================================================
// s2p_converter_if: serial input and parallel output handshakes of s2p_converter
// Rev 1.0
// ============================================================================
`default_nettype none

interface s2p_converter_if #(
   parameter int N = 4
) ();

   logic         ser_valid;
   logic         ser_data;
   logic         ser_ready;
   logic [N-1:0] par_data;
   logic         par_valid;
   logic         par_ready;

   modport master (
      output ser_valid,
      output ser_data,
      input  ser_ready,
      input  par_data,
      input  par_valid,
      output par_ready
   );

   modport slave (
      input  ser_valid,
      input  ser_data,
      output ser_ready,
      output par_data,
      output par_valid,
      input  par_ready
   );

endinterface

`default_nettype wire

// File: rtl/s2p_out_reg.sv
// ============================================================================
// s2p_out_reg: parallel holding register with valid/ready for double buffering
// Rev 1.0
// ============================================================================
`default_nettype none

module s2p_out_reg #(
   parameter int N = 4
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         clr,
   input  wire logic         load,
   input  wire logic [N-1:0] load_data,
   input  wire logic         take,
   output logic [N-1:0]      data,
   output logic              valid
);

   // A load coinciding with a take replaces the word and keeps valid high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (clr) begin
         valid <= 1'b0;
      end else if (load) begin
         data  <= load_data;
         valid <= 1'b1;
      end else if (valid && take) begin
         valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/s2p_converter.sv
// ============================================================================
// s2p_converter: MSB-first serial to N-bit parallel converter
// Optional double-buffered output: define S2P_DOUBLE_BUF_EN. Rev 1.0
// ============================================================================
`default_nettype none

module s2p_converter
   import s2p_pkg::*;
#(
   parameter int N = 4
) (
   input wire logic       clk,
   input wire logic       rst,
   input wire logic       clr,
   s2p_converter_if.slave bus
);

   localparam int               CNT_W  = cnt_width(N);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

   logic [N-1:0]     r_shift;
   logic [CNT_W-1:0] r_count;
   logic             w_ser_beat;
   logic             w_last_beat;
   logic [N-1:0]     w_shift_next;

   assign w_ser_beat   = bus.ser_valid && bus.ser_ready;
   assign w_last_beat  = w_ser_beat && (r_count == C_LAST);
   assign w_shift_next = {r_shift[N-2:0], bus.ser_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (w_ser_beat) begin
         r_shift <= w_shift_next;
         r_count <= w_last_beat ? '0 : r_count + 1'b1;
      end
   end

`ifdef S2P_DOUBLE_BUF_EN

   logic w_out_valid;

   s2p_out_reg #(
      .N (N)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .load      (w_last_beat && !clr),
      .load_data (w_shift_next),
      .take      (bus.par_ready),
      .data      (bus.par_data),
      .valid     (w_out_valid)
   );

   // Stall only the final bit, and only while the previous word is still unclaimed.
   assign bus.ser_ready = !((r_count == C_LAST) && w_out_valid && !bus.par_ready);
   assign bus.par_valid = w_out_valid;

`else

   s2p_state_e r_state;
   s2p_state_e w_state_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (clr) begin
         w_state_next = FILL;
      end else begin
         case (r_state)
            FILL:    if (w_last_beat)   w_state_next = HOLD;
            HOLD:    if (bus.par_ready) w_state_next = FILL;
            default: w_state_next = FILL;
         endcase
      end
   end

   assign bus.ser_ready = (r_state == FILL);
   assign bus.par_valid = (r_state == HOLD);
   assign bus.par_data  = r_shift;

`endif

endmodule

`default_nettype wire

// File: tb/tb_s2p_converter.sv
// ============================================================================
// tb_s2p_converter: directed and randomized bench for s2p_converter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_s2p_converter;

`ifdef S2P_DOUBLE_BUF_EN
   localparam int EXP_BP_ACC = 3;
   localparam int EXP_PERIOD = 4;
`else
   localparam int EXP_BP_ACC = 0;
   localparam int EXP_PERIOD = 5;
`endif

   logic clk = 1'b0;
   logic rst;
   logic clr;
   logic clr8;

   int tests = 0;
   int fails = 0;

   s2p_converter_if #(.N(4)) bus4 ();
   s2p_converter_if #(.N(8)) bus8 ();

   s2p_converter #(.N(4)) dut  (.clk(clk), .rst(rst), .clr(clr),  .bus(bus4.slave));
   s2p_converter #(.N(8)) dut8 (.clk(clk), .rst(rst), .clr(clr8), .bus(bus8.slave));

   always #5 clk = ~clk;

   int         cyc = 0;
   logic       mon_en = 1'b0;
   logic [3:0] got_q[$];
   int         got_t[$];
   logic [7:0] lb_out[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_en && bus4.par_valid && bus4.par_ready) begin
         got_q.push_back(bus4.par_data);
         got_t.push_back(cyc);
      end
      if (bus8.par_valid && bus8.par_ready) lb_out.push_back(bus8.par_data);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send4(input logic b);
      bus4.ser_valid = 1'b1;
      bus4.ser_data  = b;
      for (int i = 0; i < 64; i++) begin
         #1;
         if (bus4.ser_ready) begin
            step();
            bus4.ser_valid = 1'b0;
            return;
         end
         step();
      end
      chk("ser_ready_timeout4", bus4.ser_ready, 1);
      bus4.ser_valid = 1'b0;
   endtask

   task automatic send8(input logic b);
      bus8.ser_valid = 1'b1;
      bus8.ser_data  = b;
      for (int i = 0; i < 64; i++) begin
         #1;
         if (bus8.ser_ready) begin
            step();
            bus8.ser_valid = 1'b0;
            return;
         end
         step();
      end
      chk("ser_ready_timeout8", bus8.ser_ready, 1);
      bus8.ser_valid = 1'b0;
   endtask

   task automatic send_word4(input logic [3:0] w);
      for (int i = 3; i >= 0; i--) send4(w[i]);
   endtask

   initial begin
      logic       hold_ok;
      int         acc;
      logic [3:0] nxt;
      logic [3:0] tp_exp[$];
      logic [7:0] lb_in[$];
      logic [7:0] lb_word;
      int         guard;

      rst = 1'b1; clr = 1'b0; clr8 = 1'b0;
      bus4.ser_valid = 1'b0; bus4.ser_data = 1'b0; bus4.par_ready = 1'b0;
      bus8.ser_valid = 1'b0; bus8.ser_data = 1'b0; bus8.par_ready = 1'b0;
      step(); step();
      chk("reset_par_valid", bus4.par_valid, 0);
      chk("reset_par_data",  bus4.par_data,  0);
      chk("reset_ser_ready", bus4.ser_ready, 1);
      rst = 1'b0;
      step();

      // Basic transfer 1,0,1,1
      bus4.par_ready = 1'b1;
      send4(1'b1); send4(1'b0); send4(1'b1);
      chk("basic_not_early", bus4.par_valid, 0);
      send4(1'b1);
      chk("basic_par_valid", bus4.par_valid, 1);
      chk("basic_par_data",  bus4.par_data,  4'b1011);
      step();
      chk("basic_drained", bus4.par_valid, 0);

      // Back-pressure on word 4'hA, next word 4'h6 offered meanwhile
      bus4.par_ready = 1'b0;
      send_word4(4'hA);
      hold_ok = 1'b1;
      acc = 0;
      nxt = 4'h6;
      for (int c = 0; c < 5; c++) begin
         bus4.ser_valid = 1'b1;
         bus4.ser_data  = (acc < 4) ? nxt[3 - acc] : 1'b0;
         #1;
         if (bus4.par_valid !== 1'b1 || bus4.par_data !== 4'hA) hold_ok = 1'b0;
         if (bus4.ser_ready) acc++;
         step();
      end
      bus4.ser_valid = 1'b0;
      chk("bp_hold",     hold_ok, 1);
      chk("bp_accepted", acc,     EXP_BP_ACC);
      bus4.par_ready = 1'b1;
      for (int i = acc; i < 4; i++) send4(nxt[3 - i]);
      chk("bp_next_valid", bus4.par_valid, 1);
      chk("bp_next_data",  bus4.par_data,  4'h6);
      step();
      chk("bp_drained", bus4.par_valid, 0);

      // Throughput: 8 random words streamed with par_ready held high
      got_q.delete(); got_t.delete();
      for (int w = 0; w < 8; w++) tp_exp.push_back(4'($urandom));
      mon_en = 1'b1;
      for (int w = 0; w < 8; w++) send_word4(tp_exp[w]);
      step(); step();
      mon_en = 1'b0;
      chk("tp_count", got_q.size(), 8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("tp_word%0d", i), (i < got_q.size()) ? got_q[i] : 4'hx, tp_exp[i]);
      for (int i = 1; i < got_t.size(); i++)
         chk($sformatf("tp_period%0d", i), got_t[i] - got_t[i-1], EXP_PERIOD);

      // Abort after 2 bits, then clr colliding with a serial beat
      send4(1'b1); send4(1'b1);
      clr = 1'b1; step(); clr = 1'b0;
      chk("abort_count", dut.r_count, 0);
      bus4.ser_valid = 1'b1; bus4.ser_data = 1'b1; clr = 1'b1;
      step();
      clr = 1'b0; bus4.ser_valid = 1'b0;
      chk("abort_prio_count", dut.r_count, 0);
      send4(1'b0); send4(1'b1); send4(1'b1);
      chk("abort_not_early", bus4.par_valid, 0);
      send4(1'b0);
      chk("abort_valid", bus4.par_valid, 1);
      chk("abort_data",  bus4.par_data,  4'b0110);
      step();

      // clr while a word is held
      bus4.par_ready = 1'b0;
      send_word4(4'h5);
      chk("clr_hold_pre", bus4.par_valid, 1);
      clr = 1'b1; step(); clr = 1'b0;
      chk("clr_hold_valid", bus4.par_valid, 0);
      chk("clr_hold_ready", bus4.ser_ready, 1);

      // Asynchronous reset while holding
      send_word4(4'h9);
      chk("rst_pre_data", bus4.par_data, 4'h9);
      #2 rst = 1'b1;
      #1;
      chk("rst_par_valid", bus4.par_valid, 0);
      chk("rst_par_data",  bus4.par_data,  0);
      rst = 1'b0;
      step();
      chk("rst_ser_ready", bus4.ser_ready, 1);

      // Loopback, N=8, random stalls on both sides
      lb_out.delete();
      guard = 0;
      fork
         begin
            for (int w = 0; w < 100; w++) begin
               lb_word = 8'($urandom);
               lb_in.push_back(lb_word);
               for (int b = 7; b >= 0; b--) begin
                  if ($urandom_range(3) == 0) repeat ($urandom_range(3, 1)) step();
                  send8(lb_word[b]);
               end
            end
         end
         begin
            while (lb_out.size() < 100 && guard < 20000) begin
               bus8.par_ready = ($urandom_range(2) != 0);
               step();
               guard++;
            end
            bus8.par_ready = 1'b0;
         end
      join
      chk("lb_count", lb_out.size(), 100);
      for (int i = 0; i < 100; i++)
         chk($sformatf("lb_word%0d", i), (i < lb_out.size()) ? lb_out[i] : 8'hxx, lb_in[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
